register_8bit: RTL and testbench
================================

REGISTER_8BIT -- requirements
Module: register_8bit

Interface
REQ-001 Parameter SIZE, default 8, data width in bits; legal range SIZE >= 1.
REQ-002 Parameter RESET_VALUE, default all-zeros (SIZE bits), value loaded into Q by reset.
REQ-003 Clock  input  1  single clock; all state updates on rising edge only.
REQ-004 Reset  input  1  reset; synchronous and active-high.
REQ-005 load  input  1  load enable; 1 = capture D at next rising Clock edge.
REQ-006 D  input  SIZE  data to be stored.
REQ-007 Q  output  SIZE  stored register contents.
REQ-008 Positional port order SHALL be (Q, D, load, Clock, Reset) so existing positional instantiations bind correctly.

Function
REQ-009 Q SHALL be driven directly from a SIZE-bit storage register; no combinational path from D, load or Reset to Q.
REQ-010 At a rising Clock edge with Reset=1, Q SHALL become RESET_VALUE, regardless of load and D.
REQ-011 At a rising Clock edge with Reset=0 and load=1, Q SHALL become the value of D sampled at that edge (latency 1 cycle).
REQ-012 At a rising Clock edge with Reset=0 and load=0, Q SHALL hold its previous value.
REQ-013 Reset SHALL have priority over load when both are 1 at the same edge.
REQ-014 Changes on D, load or Reset between rising edges SHALL NOT affect Q until the next rising edge.
REQ-015 With load held at 1, Q SHALL follow D with a one-cycle delay on every edge, including back-to-back different values.
REQ-016 All SIZE bits SHALL be loaded, held and reset together; no partial-bit updates.
REQ-017 D values narrower than SIZE at the source are zero-extended by the driver; the block stores exactly the SIZE bits presented.
REQ-018 Before the first rising edge with Reset=1, Q is unspecified; verification SHALL not check Q before the first reset edge.

Reset
REQ-019 Reset is sampled only on rising Clock edges; asserting Reset between edges SHALL NOT change Q until the next edge.
REQ-020 Reset asserted mid-operation (load active, D changing) SHALL force Q to RESET_VALUE at the next edge and hold it for every edge Reset remains 1.
REQ-021 On the first edge after Reset returns to 0, normal load/hold behaviour SHALL resume (load=1 captures D on that edge).

Verification
REQ-022 Reset=1, load=1, D=8'b1100_1011, one edge -> Q=8'h00 (reset priority).
REQ-023 Reset=0, load=1, D=8'b0000_0110, one edge -> Q=8'b0000_0110; then D=8'b1100_1011, one edge -> Q=8'b1100_1011; then D=8'b0001_1011, one edge -> Q=8'b0001_1011.
REQ-024 Q=8'hA5, load=0, D toggled through 8'h00/8'hFF over 5 edges -> Q stays 8'hA5.
REQ-025 D changed between edges with load=1 -> Q updates only at next rising edge, never mid-cycle.
REQ-026 Reset pulsed for one edge while load=1 streams data -> Q=8'h00 on that edge, next edge Q equals current D.
REQ-027 Instance with SIZE=5: load 5'b10110 -> Q=5'b10110; reset -> Q=5'b00000.

Source files
------------

// File: rtl/register_8bit.sv
// register_8bit: SIZE-bit storage register with load enable and a
// synchronous, active-high reset that takes priority over load.
// Q comes straight from the storage flops, so D, load and Reset only
// reach Q through a rising Clock edge.
module register_8bit #(
   // Data width in bits; legal range SIZE >= 1.
   parameter int unsigned     SIZE        = 8,
   // Value loaded into Q by reset.
   parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
   // Positional order is (Q, D, load, Clock, Reset) so that existing
   // positional instantiations still bind correctly.
   output logic [SIZE-1:0] Q,
   input  logic [SIZE-1:0] D,
   input  logic            load,
   input  logic            Clock,
   input  logic            Reset
);

   logic [SIZE-1:0] q_d;
   logic [SIZE-1:0] q_q;

   // Next-state selection: capture D when load is high, otherwise hold.
   always_comb begin
      // NOTE: q_d gets a default before any branch so no path leaves it unassigned (no latch).
      q_d = q_q;
      if (load) begin
         q_d = D;
      end
   end

   // Storage flops: reset is sampled on the edge and wins over load.
   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (Reset) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

endmodule

// File: tb/tb_register_8bit.sv
// tb_register_8bit: scoreboard bench. The stimulus process pushes one
// hand-computed expectation per clock edge into a queue; an independent
// monitor pops and compares shortly after each rising edge.
module tb_register_8bit;

   typedef struct {
      int         sel;   // 0: default 8-bit, 1: SIZE=5, 2: RESET_VALUE=8'h3C
      logic [7:0] exp;
      string      name;
   } exp_t;

   logic       Clock;
   logic       Reset;
   logic       load;
   logic [7:0] d;
   logic [7:0] q8;
   logic [4:0] q5;
   logic [7:0] qrv;

   exp_t sb[$];
   int   n_cmp;
   int   n_bad;

   register_8bit u_dut8 (
      .Q     (q8),
      .D     (d),
      .load  (load),
      .Clock (Clock),
      .Reset (Reset)
   );

   register_8bit #(.SIZE(5)) u_dut5 (
      .Q     (q5),
      .D     (d[4:0]),
      .load  (load),
      .Clock (Clock),
      .Reset (Reset)
   );

   register_8bit #(.SIZE(8), .RESET_VALUE(8'h3C)) u_dutrv (
      .Q     (qrv),
      .D     (d),
      .load  (load),
      .Clock (Clock),
      .Reset (Reset)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one edge's inputs at the falling edge, queue its expectation, wait for the edge.
   task automatic step(input int sel, input logic rst, input logic ld,
                       input logic [7:0] din, input logic [7:0] exp, input string name);
      exp_t e;
      @(negedge Clock);
      Reset = rst;
      load  = ld;
      d     = din;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
      @(posedge Clock);
   endtask

   // Monitor: compare each queued expectation just after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
               1:       check(e.name, {3'b000, q5}, e.exp);
               2:       check(e.name, qrv, e.exp);
               default: check(e.name, q8, e.exp);
            endcase
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      Reset = 1'b0;
      load  = 1'b0;
      d     = 8'h00;

      // Q is unspecified before the first reset edge: run one edge unchecked.
      @(negedge Clock);
      @(posedge Clock);

      // Reset wins over load.
      step(0, 1'b1, 1'b1, 8'b1100_1011, 8'h00, "rst_priority");

      // Back-to-back loads.
      step(0, 1'b0, 1'b1, 8'b0000_0110, 8'b0000_0110, "load_06");
      step(0, 1'b0, 1'b1, 8'b1100_1011, 8'b1100_1011, "load_cb");
      step(0, 1'b0, 1'b1, 8'b0001_1011, 8'b0001_1011, "load_1b");

      // Hold with D toggling.
      step(0, 1'b0, 1'b1, 8'hA5, 8'hA5, "load_a5");
      for (int i = 0; i < 5; i++) begin
         step(0, 1'b0, 1'b0, (i % 2 == 0) ? 8'h00 : 8'hFF, 8'hA5, "hold_a5");
      end

      // Mid-cycle changes on D and Reset must not reach Q.
      step(0, 1'b0, 1'b1, 8'h3C, 8'h3C, "load_3c");
      #3;
      d     = 8'h99;
      Reset = 1'b1;
      #1;
      check("mid_cycle_d_rst", q8, 8'h3C);
      Reset = 1'b0;
      step(0, 1'b0, 1'b1, 8'h77, 8'h77, "load_after_mid");

      // One-edge reset pulse while streaming.
      step(0, 1'b0, 1'b1, 8'h11, 8'h11, "stream_11");
      step(0, 1'b0, 1'b1, 8'h22, 8'h22, "stream_22");
      step(0, 1'b1, 1'b1, 8'h33, 8'h00, "stream_rst");
      step(0, 1'b0, 1'b1, 8'h44, 8'h44, "stream_44");
      step(0, 1'b0, 1'b1, 8'h55, 8'h55, "stream_55");

      // Reset held over several edges, then first edge after release loads.
      step(0, 1'b1, 1'b1, 8'hE1, 8'h00, "rst_hold_1");
      step(0, 1'b1, 1'b1, 8'hE2, 8'h00, "rst_hold_2");
      step(0, 1'b1, 1'b0, 8'hE3, 8'h00, "rst_hold_3");
      step(0, 1'b0, 1'b1, 8'h66, 8'h66, "rst_release_load");
      step(0, 1'b0, 1'b0, 8'h00, 8'h66, "hold_66");

      // Non-default RESET_VALUE instance.
      step(2, 1'b1, 1'b0, 8'h00, 8'h3C, "rv_reset");
      step(2, 1'b0, 1'b0, 8'hFF, 8'h3C, "rv_hold");
      step(2, 1'b0, 1'b1, 8'h5A, 8'h5A, "rv_load");
      step(2, 1'b1, 1'b1, 8'hFF, 8'h3C, "rv_rst_priority");

      // SIZE=5 instance (driven from D[4:0]).
      step(1, 1'b1, 1'b0, 8'h00, 8'h00, "s5_reset");
      step(1, 1'b0, 1'b1, 8'hF6, 8'h16, "s5_load_10110");
      step(1, 1'b0, 1'b0, 8'h1F, 8'h16, "s5_hold");
      step(1, 1'b0, 1'b1, 8'h09, 8'h09, "s5_load_01001");
      step(1, 1'b1, 1'b1, 8'h1F, 8'h00, "s5_rst");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && sb.size() > 0; i++) begin
         @(posedge Clock);
         #2;
      end
      if (sb.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
